// File: rtl/branch_resolve_ctrl_if.sv
// Decode/execute-side port bundle for branch_resolve_ctrl.
// The slave modport is the controller; the master modport is the pipeline driving it.
interface branch_resolve_ctrl_if #(parameter int AW = 32);
  logic          stall;
  logic          dec_branch;
  logic          dec_pred;
  logic [AW-1:0] dec_target;
  logic [AW-1:0] dec_pc4;
  logic          ex_valid;
  logic          ex_taken;
  logic          full;
  logic          bpu_branch;
  logic          bpu_miss;
  logic          flush;
  logic [AW-1:0] redirect_pc;

  modport slave (
    input  stall, dec_branch, dec_pred, dec_target, dec_pc4, ex_valid, ex_taken,
    output full, bpu_branch, bpu_miss, flush, redirect_pc
  );

  modport master (
    output stall, dec_branch, dec_pred, dec_target, dec_pc4, ex_valid, ex_taken,
    input  full, bpu_branch, bpu_miss, flush, redirect_pc
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order branch resolution queue: tracks predicted branches, resolves the oldest, flushes on mispredict.
// Optional resolve/mispredict counters are built when BRC_STATS_EN is defined.
module branch_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_ctrl_if.slave bus
`ifdef BRC_STATS_EN
  ,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_misses
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic          pred;
    logic [AW-1:0] target;
    logic [AW-1:0] pc4;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head, wr_entry;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          bpu_branch_q, bpu_branch_d;
  logic          bpu_miss_q, bpu_miss_d;
  logic          flush_q, flush_d;
  logic [AW-1:0] redirect_pc_q, redirect_pc_d;
  logic          full, resolve, mispredict_now, enq;

  always_comb begin
    head           = mem_q[rd_ptr_q];
    full           = (count_q == (PW+1)'(DEPTH));
    resolve        = bus.ex_valid & ~bus.stall & (count_q != '0);
    mispredict_now = resolve & (bus.ex_taken != head.pred);
    // a branch decoded alongside a mispredict is on the wrong path
    enq            = bus.dec_branch & ~bus.stall & ~full & ~mispredict_now;
    wr_entry       = '{pred: bus.dec_pred, target: bus.dec_target, pc4: bus.dec_pc4};
  end

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    bpu_branch_d  = resolve;
    bpu_miss_d    = mispredict_now;
    flush_d       = mispredict_now;
    redirect_pc_d = redirect_pc_q;
    if (mispredict_now) begin
      count_d       = '0;
      rd_ptr_d      = wr_ptr_q;
      redirect_pc_d = bus.ex_taken ? head.target : head.pc4;
    end else begin
      if (enq)     wr_ptr_d = wr_ptr_q + 1'b1;
      if (resolve) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq, resolve})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      bpu_branch_q  <= 1'b0;
      bpu_miss_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      bpu_branch_q  <= bpu_branch_d;
      bpu_miss_q    <= bpu_miss_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // payload is qualified by count, so it carries no reset
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.full        = full;
  assign bus.bpu_branch  = bpu_branch_q;
  assign bus.bpu_miss    = bpu_miss_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;

`ifdef BRC_STATS_EN
  logic [15:0] stat_branches_q, stat_branches_d;
  logic [15:0] stat_misses_q, stat_misses_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_misses_d   = stat_misses_q;
    if (resolve && stat_branches_q != 16'hFFFF)      stat_branches_d = stat_branches_q + 16'd1;
    if (mispredict_now && stat_misses_q != 16'hFFFF) stat_misses_d   = stat_misses_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_misses_q   <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_misses_q   <= stat_misses_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_misses   = stat_misses_q;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl (DEPTH=4, AW=32): vector table plus
// hand-written reset and saturation sequences.
module tb_branch_resolve_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.AW(32)) bif ();

`ifdef BRC_STATS_EN
  logic [15:0] stat_branches, stat_misses;
  branch_resolve_ctrl #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .bus(bif),
    .stat_branches(stat_branches), .stat_misses(stat_misses));
`else
  branch_resolve_ctrl #(.DEPTH(4), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bif));
`endif

  typedef struct {
    logic        st, dec, pr;
    logic [31:0] tg, p4;
    logic        ev, et;
    logic        e_full, e_bb, e_bm, e_fl;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic        bb, bm, fl;
    logic [31:0] rd;
    int          idx;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic add(input logic st, dec, pr, input logic [31:0] tg, p4,
                     input logic ev, et, ef, bb, bm, fl, input logic [31:0] rd);
    vt.push_back('{st, dec, pr, tg, p4, ev, et, ef, bb, bm, fl, rd});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, dec, pr, input logic [31:0] tg, p4, input logic ev, et);
    bif.stall = st; bif.dec_branch = dec; bif.dec_pred = pr;
    bif.dec_target = tg; bif.dec_pc4 = p4; bif.ex_valid = ev; bif.ex_taken = et;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk($sformatf("%s[%0d].bpu_branch", tag, e.idx), {31'd0, bif.bpu_branch}, {31'd0, e.bb});
    chk($sformatf("%s[%0d].bpu_miss", tag, e.idx), {31'd0, bif.bpu_miss}, {31'd0, e.bm});
    chk($sformatf("%s[%0d].flush", tag, e.idx), {31'd0, bif.flush}, {31'd0, e.fl});
    chk($sformatf("%s[%0d].redirect_pc", tag, e.idx), bif.redirect_pc, e.rd);
  endtask

  initial begin
    exp_t e;
    //   st dec pr target        pc4           ev et | full bb bm fl redirect
    add(0, 0, 0, 32'h0,        32'h0,        0, 0,   0,  0, 0, 0, 32'h0);
    add(0, 1, 1, 32'h100,      32'h014,      0, 0,   0,  0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h0,        1, 1,   0,  1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0,   0,  0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h200,      32'h024,      0, 0,   0,  0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h0,        1, 1,   0,  1, 1, 1, 32'h200);
    add(0, 0, 0, 32'h0,        32'h0,        0, 0,   0,  0, 0, 0, 32'h200);
    add(0, 0, 0, 32'h0,        32'h0,        1, 1,   0,  0, 0, 0, 32'h200);
    add(0, 1, 1, 32'h1000,     32'h1004,     0, 0,   0,  0, 0, 0, 32'h200);
    add(0, 1, 0, 32'h2000,     32'h2004,     0, 0,   0,  0, 0, 0, 32'h200);
    add(0, 1, 1, 32'h3000,     32'h3004,     0, 0,   0,  0, 0, 0, 32'h200);
    add(0, 1, 0, 32'h4000,     32'h4004,     0, 0,   0,  0, 0, 0, 32'h200);
    add(0, 1, 1, 32'h5000,     32'h5004,     0, 0,   1,  0, 0, 0, 32'h200);
    add(0, 1, 1, 32'h5000,     32'h5004,     1, 1,   1,  1, 0, 0, 32'h200);
    add(0, 1, 1, 32'h5000,     32'h5004,     0, 0,   0,  0, 0, 0, 32'h200);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0,   1,  1, 0, 0, 32'h200);
    add(0, 1, 0, 32'h6000,     32'h6004,     1, 1,   0,  1, 0, 0, 32'h200);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0,   0,  1, 0, 0, 32'h200);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0,   0,  1, 1, 1, 32'h5004);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0,   0,  0, 0, 0, 32'h5004);
    add(0, 1, 1, 32'h7000,     32'h7004,     0, 0,   0,  0, 0, 0, 32'h5004);
    add(0, 1, 1, 32'h8000,     32'h8004,     0, 0,   0,  0, 0, 0, 32'h5004);
    add(0, 1, 0, 32'h9000,     32'h9004,     0, 0,   0,  0, 0, 0, 32'h5004);
    add(0, 1, 1, 32'hA000,     32'hA004,     1, 0,   0,  1, 1, 1, 32'h7004);
    add(0, 0, 0, 32'h0,        32'h0,        1, 1,   0,  0, 0, 0, 32'h7004);
    add(0, 1, 1, 32'hB000,     32'hB004,     0, 0,   0,  0, 0, 0, 32'h7004);
    add(1, 1, 0, 32'hC000,     32'hC004,     1, 0,   0,  0, 0, 0, 32'h7004);
    add(0, 0, 0, 32'h0,        32'h0,        1, 1,   0,  1, 0, 0, 32'h7004);
    add(0, 0, 0, 32'h0,        32'h0,        1, 0,   0,  0, 0, 0, 32'h7004);

    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    e = '{bb: 0, bm: 0, fl: 0, rd: 32'h0, idx: 0};
    check_outs("reset", e);
    chk("reset.full", {31'd0, bif.full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;

    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].dec, vt[i].pr, vt[i].tg, vt[i].p4, vt[i].ev, vt[i].et);
      #1;
      chk($sformatf("vec[%0d].full", i), {31'd0, bif.full}, {31'd0, vt[i].e_full});
      sb.push_back('{bb: vt[i].e_bb, bm: vt[i].e_bm, fl: vt[i].e_fl, rd: vt[i].e_rd, idx: i});
      step();
      e = sb.pop_front();
      check_outs("vec", e);
    end

    // Reset between edges with two entries queued and bpu_branch high.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 32'hD000 + k, 32'hD004 + k, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst.bpu_branch", {31'd0, bif.bpu_branch}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    e = '{bb: 0, bm: 0, fl: 0, rd: 32'h0, idx: 0};
    check_outs("async_rst", e);
    chk("async_rst.full", {31'd0, bif.full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    check_outs("post_rst_empty", e);

    // Count restarts from zero: full only after the fourth enqueue.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 32'hE000 + k, 32'hE004 + k, 0, 0);
      #1;
      chk($sformatf("refill[%0d].full", k), {31'd0, bif.full}, 32'd0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("refill.full_at_depth", {31'd0, bif.full}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_full.full", {31'd0, bif.full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef BRC_STATS_EN
    chk("stats.reset_branches", {16'd0, stat_branches}, 32'd0);
    drive(0, 1, 1, 32'hF000, 32'hF004, 0, 0);
    step();
    drive(0, 1, 1, 32'hF000, 32'hF004, 1, 1);
    for (int k = 0; k < 65540; k++) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("stats.branches_sat", {16'd0, stat_branches}, 32'h0000FFFF);
    chk("stats.misses", {16'd0, stat_misses}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
